// File: rtl/axi_rr_mux_pkg.sv
// Shared constants and the grant search used by the arbitrated AXI channel mux.
package axi_rr_mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // The grant search works on a fixed-width vector so one function serves
  // every instance width; callers zero-extend their valid vector.
  localparam int MAX_IN = 64;
  localparam int IDX_W  = 6;

  typedef struct packed {
    logic             any;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First asserted valid found searching ptr, ptr+1, ... wrapping at n.
  // A ptr of 0 gives lowest-index-wins, which the fixed-priority mode uses.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] valid,
                                    input int                ptr,
                                    input int                n);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = 0; k < MAX_IN; k++) begin
      if (k < n) begin
        cand = ptr + k;
        if (cand >= n) cand = cand - n;
        if (!res.any && valid[cand]) begin
          res.any = 1'b1;
          res.idx = IDX_W'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Stateless grant logic: picks one valid input by round-robin pointer or by
// fixed priority, and presents it both as an index and as a one-hot vector.
module axi_rr_arbiter
  import axi_rr_mux_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int ARB_MODE  = ARB_RR,
  parameter int SEL_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]      valid,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic [N_IN-1:0]      grant_oh,
  output logic                 any_valid
);

  logic [MAX_IN-1:0] valid_ext;
  pick_t             pick;

  // Search for the winner and expand it into index and one-hot forms.
  always_comb begin
    valid_ext             = '0;
    valid_ext[N_IN-1:0]   = valid;
    pick = rr_pick(valid_ext, (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr), N_IN);
    grant_idx = SEL_WIDTH'(pick.idx);
    any_valid = pick.any;
    grant_oh  = '0;
    for (int i = 0; i < N_IN; i++) begin
      grant_oh[i] = pick.any && (int'(pick.idx) == i);
    end
  end

endmodule

// File: rtl/axi_rr_multiplexer.sv
// Registered N-to-1 mux for one AXI channel payload. A single output register
// breaks the timing path while still accepting a new beat on the same cycle
// the held one drains, so throughput stays at one beat per cycle.
module axi_rr_multiplexer
  import axi_rr_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_IN       = 4,
  parameter int ARB_MODE   = ARB_RR,
  parameter int SEL_WIDTH  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN-1:0]            IN_VALID,
  input  logic [N_IN*DATA_WIDTH-1:0] IN_DATA,
  output logic [N_IN-1:0]            IN_READY,
  output logic                       OUT_VALID,
  output logic [DATA_WIDTH-1:0]      OUT_DATA,
  input  logic                       OUT_READY,
  output logic [SEL_WIDTH-1:0]       OUT_SEL
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SEL_WIDTH-1:0]  out_sel_q;
  logic [SEL_WIDTH-1:0]  rr_ptr_q;

  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [N_IN-1:0]       grant_oh;
  logic                  any_valid;
  logic                  load;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [SEL_WIDTH-1:0]  rr_ptr_next;

  axi_rr_arbiter #(
    .N_IN      (N_IN),
    .ARB_MODE  (ARB_MODE),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arbiter (
    .valid     (IN_VALID),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh),
    .any_valid (any_valid)
  );

  // Load when the register is empty or draining; acknowledge only the winner.
  // rst_n gates the ready so nothing is accepted while the held beat is dropped.
  always_comb begin
    load        = !out_valid_q || OUT_READY;
    IN_READY    = (load && rst_n) ? grant_oh : '0;
    grant_data  = IN_DATA[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    rr_ptr_next = (grant_idx == SEL_WIDTH'(N_IN - 1)) ? '0
                                                      : grant_idx + SEL_WIDTH'(1);
  end

  // Output register and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_sel_q   <= grant_idx;
        if (ARB_MODE == ARB_RR) rr_ptr_q <= rr_ptr_next;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_SEL   = out_sel_q;

endmodule

// File: doc/axi_rr_multiplexer.md
Name: axi_rr_multiplexer

Overview:
Registered, arbitrated N-to-1 multiplexer for one AXI channel (AW, AR, W, R or B payload), for use inside the AXI node.
- Selection is decided internally by a round-robin or fixed-priority arbiter, not by an external select.
- Full valid/ready handshaking on every input and on the output.
- A one-deep output register breaks the combinational path. It sustains one transfer per cycle under continuous OUT_READY.

Parameters:
DATA_WIDTH, 64, payload width in bits
N_IN, 4, number of input channels (>=1, need not be a power of two)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
SEL_WIDTH, (N_IN>1 ? $clog2(N_IN) : 1), width of the grant index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active low
IN_VALID  in  N_IN  per-input valid
IN_DATA  in  N_IN x DATA_WIDTH  packed per-input payload
IN_READY  out  N_IN  per-input ready (one-hot or zero)
OUT_VALID  out  1  output valid
OUT_DATA  out  DATA_WIDTH  output payload
OUT_READY  in  1  downstream ready
OUT_SEL  out  SEL_WIDTH  index of the input that supplied OUT_DATA

Behaviour:
Clocking and reset
- One clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, rr_ptr=0.
- IN_READY is combinational and therefore 0 while no input is valid.
- Reset asserted mid-transfer drops the held beat; no input is acknowledged in that cycle.

State
- out_valid_q, out_data_q, out_sel_q, rr_ptr_q (SEL_WIDTH bits, range 0..N_IN-1).

Load and grant
- load = !out_valid_q || OUT_READY.
- Round-robin grant: the first asserted IN_VALID[i] searching i = rr_ptr_q, rr_ptr_q+1, ... mod N_IN.
- Fixed-priority grant: the lowest asserted index; rr_ptr_q is unused.
- IN_READY[g] = load && IN_VALID[g] for the granted g only; all other IN_READY bits are 0. IN_READY never depends on OUT_VALID alone.
- Handshake on input g completes when IN_VALID[g] && IN_READY[g].

Register update on a clock edge
- load && some valid: out_data_q <= IN_DATA[g], out_sel_q <= g, out_valid_q <= 1. In round-robin mode, rr_ptr_q <= (g == N_IN-1) ? 0 : g+1.
- load && no valid: out_valid_q <= 0; data, sel and rr_ptr hold.
- !load (stalled): all state holds. OUT_DATA and OUT_SEL stay stable while OUT_VALID && !OUT_READY (AXI stability rule).

Timing
- Latency is exactly 1 cycle from input handshake to OUT_VALID.
- Throughput is 1 beat per cycle with OUT_READY held high. No bubble when the register drains and refills in the same cycle.

Boundary conditions
- N_IN=1: the arbiter degenerates, OUT_SEL is always 0, and rr_ptr stays 0.
- Non-power-of-two N_IN: rr_ptr wraps explicitly from N_IN-1 to 0. Values >= N_IN are unreachable.
- A valid input that is not granted keeps waiting; inputs may withdraw valid freely; no data is lost.
- Fairness (round-robin): with all inputs continuously valid, each input is granted exactly once every N_IN beats.

Decomposition:
Package axi_rr_mux_pkg holds:
- the ARB_MODE localparams ARB_RR=0 and ARB_FIXED=1;
- a function rr_pick(valid, ptr) returning the granted index and an any-valid flag.

One sub-module, axi_rr_arbiter, is natural:
- combinational grant index and one-hot grant from IN_VALID and rr_ptr_q, covering both modes;
- it contains no state.

The top level holds the output register, rr_ptr_q and the load/handshake logic.

Test Plan:
1. Reset: drive rst_n=0 with random inputs -> OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, IN_READY=0. Release reset with IN_VALID=0 -> outputs unchanged.
2. Single input, N_IN=4, ARB_MODE=0: IN_VALID=4'b0100, IN_DATA[2]=64'hCAFE, OUT_READY=1 -> IN_READY=4'b0100 that cycle. Next cycle OUT_VALID=1, OUT_DATA=64'hCAFE, OUT_SEL=2.
3. Round-robin fairness: IN_VALID=4'b1111 held, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0,1 on consecutive cycles, no idle cycles.
4. Backpressure: output holding input 1's beat, OUT_READY=0 for 5 cycles, IN_VALID=4'b1111 -> IN_READY=0 and OUT_DATA/OUT_SEL stable for 5 cycles. When OUT_READY=1, the next grant is input 2.
5. Fixed priority (ARB_MODE=1): IN_VALID=4'b1010 held -> OUT_SEL=1 on every beat and input 3 is never granted. Drop IN_VALID[1] -> next OUT_SEL=3.
6. N_IN=3, ARB_MODE=0: IN_VALID=3'b111 held -> OUT_SEL sequence 0,1,2,0. rr_ptr wraps to 0 and never reaches 3.
